// File: rtl/mfp_memory_pkg.sv
// Shared constants and parameter helpers for the mfp on-chip memories.
package mfp_memory_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned num_bytes(input int unsigned data_width);
    return data_width / BYTE_WIDTH;
  endfunction

  // Only one or two cycles of read latency are implemented.
  function automatic bit read_latency_ok(input int unsigned latency);
    return (latency == 1) || (latency == 2);
  endfunction

endpackage

// File: rtl/mfp_dual_port_ram_be_if.sv
// Read/write bus of mfp_dual_port_ram_be. The master drives requests, the
// slave (the RAM) returns read_valid/read_data.
interface mfp_dual_port_ram_be_if
  import mfp_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH);

  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_valid;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [NUM_BYTES-1:0]  write_byte_enable;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output read_enable, read_addr, write_enable, write_addr, write_byte_enable, write_data,
    input  read_valid, read_data
  );

  modport slave (
    input  read_enable, read_addr, write_enable, write_addr, write_byte_enable, write_data,
    output read_valid, read_data
  );

endinterface

// File: rtl/mfp_dpram_lane.sv
// One byte lane of the dual-port RAM: 8-bit x 2^ADDR_WIDTH array, one write
// port, one registered read port. Reads see the old content on a same-address
// write (read-first).
module mfp_dpram_lane
  import mfp_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [BYTE_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [BYTE_WIDTH-1:0] read_data
);

  logic [BYTE_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write.
  // NOTE: the array itself has no reset so it maps onto block RAM and keeps
  // its contents across rst; only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              read_data <= '0;
    else if (read_enable) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/mfp_dual_port_ram_be.sv
// Simple dual-port RAM with per-byte write enables and a gated, valid-flagged
// read port of 1 or 2 cycles latency.
// Optional feature macro: MFP_DPRAM_WRITE_BYPASS_EN -- a read colliding with a
// write to the same address returns the newly written bytes; otherwise the
// old word is returned (read-first).
// INIT_FILENAME names a hex preload image; loading it is left to the
// simulation environment, this RTL only reports the name.
module mfp_dual_port_ram_be
  import mfp_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 1,
  parameter string       INIT_FILENAME = ""
) (
  input logic                  clk,
  input logic                  rst,
  mfp_dual_port_ram_be_if.slave bus
);

  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("mfp_dual_port_ram_be: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("mfp_dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if (INIT_FILENAME != "") begin : g_init_note
    $info("mfp_dual_port_ram_be: preload image %s", INIT_FILENAME);
  end

  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] lane_rdata;
  logic [DATA_WIDTH-1:0]                merged_data;
  logic                                 stage1_valid;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    mfp_dpram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .write_enable (bus.write_enable & bus.write_byte_enable[i]),
      .write_addr   (bus.write_addr),
      .write_data   (bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH]),
      .read_enable  (bus.read_enable),
      .read_addr    (bus.read_addr),
      .read_data    (lane_rdata[i])
    );
  end

  // First-stage valid: tracks the array read registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage1_valid <= 1'b0;
    else     stage1_valid <= bus.read_enable;
  end

`ifdef MFP_DPRAM_WRITE_BYPASS_EN
  logic                  collision_q;
  logic [DATA_WIDTH-1:0] bypass_data_q;
  logic [NUM_BYTES-1:0]  bypass_mask_q;

  // Capture collision info alongside the array read it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_q   <= 1'b0;
      bypass_data_q <= '0;
      bypass_mask_q <= '0;
    end else if (bus.read_enable) begin
      collision_q   <= bus.write_enable && (bus.write_addr == bus.read_addr);
      bypass_data_q <= bus.write_data;
      bypass_mask_q <= bus.write_byte_enable;
    end
  end

  // Per-byte merge of forwarded write data over the old array word.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on the bytes that are not overridden.
  always_comb begin
    merged_data = lane_rdata;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (collision_q && bypass_mask_q[i])
        merged_data[i*BYTE_WIDTH +: BYTE_WIDTH] = bypass_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
`else
  assign merged_data = lane_rdata;
`endif

  if (READ_LATENCY == 2) begin : g_out_reg
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Second output stage; data only loads when a result is arriving.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= stage1_valid;
        if (stage1_valid) out_data_q <= merged_data;
      end
    end

    assign bus.read_valid = out_valid_q;
    assign bus.read_data  = out_data_q;
  end else begin : g_out_direct
    assign bus.read_valid = stage1_valid;
    assign bus.read_data  = merged_data;
  end

endmodule

// File: tb/tb_mfp_dual_port_ram_be.sv
// Bench for mfp_dual_port_ram_be: one instance per read latency on shared
// stimulus, compared every cycle against a word-array reference model.
module tb_mfp_dual_port_ram_be;
  import mfp_memory_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mfp_dual_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  mfp_dual_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus2.read_enable       = bus1.read_enable;
  assign bus2.read_addr         = bus1.read_addr;
  assign bus2.write_enable      = bus1.write_enable;
  assign bus2.write_addr        = bus1.write_addr;
  assign bus2.write_byte_enable = bus1.write_byte_enable;
  assign bus2.write_data        = bus1.write_data;

  mfp_dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut_l1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  mfp_dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut_l2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  // Reference model: word array plus a list of scheduled results per latency.
  logic [DW-1:0] ref_mem [2**AW];
  result_t       q1[$];
  result_t       q2[$];
  logic [DW-1:0] last1, last2;
  int            cyc;
  int            n_vec, n_bad;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
  endtask

  // Compare both instances with whatever the model says is due this cycle.
  task automatic check_outputs();
    logic v1, v2;
    v1 = 1'b0;
    v2 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin v1 = 1'b1; last1 = q1.pop_front().data; end
    if (q2.size() > 0 && q2[0].due == cyc) begin v2 = 1'b1; last2 = q2.pop_front().data; end
    check("l1_valid", {31'b0, bus1.read_valid}, {31'b0, v1});
    check("l1_data",  bus1.read_data, last1);
    check("l2_valid", {31'b0, bus2.read_valid}, {31'b0, v2});
    check("l2_data",  bus2.read_data, last2);
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare shortly after.
  task automatic cycle(input logic re, input logic [AW-1:0] ra, input logic we,
                       input logic [AW-1:0] wa, input logic [NB-1:0] be, input logic [DW-1:0] wd);
    logic [DW-1:0] res;
    @(negedge clk);
    bus1.read_enable       = re;
    bus1.read_addr         = ra;
    bus1.write_enable      = we;
    bus1.write_addr        = wa;
    bus1.write_byte_enable = be;
    bus1.write_data        = wd;
    @(posedge clk);
    cyc++;
    if (re) begin
      res = ref_mem[ra];
`ifdef MFP_DPRAM_WRITE_BYPASS_EN
      if (we && wa == ra)
        for (int i = 0; i < NB; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
`endif
      q1.push_back('{due: cyc,     data: res});
      q2.push_back('{due: cyc + 1, data: res});
    end
    if (we)
      for (int i = 0; i < NB; i++) if (be[i]) ref_mem[wa][8*i +: 8] = wd[8*i +: 8];
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    cycle(1'b0, '0, 1'b1, a, be, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic expect_both(input string tag, input logic [DW-1:0] exp);
    check({tag, "_l1"}, bus1.read_data, exp);
    check({tag, "_l2"}, bus2.read_data, exp);
  endtask

  // Reset pulse; with keep_read the read request stays on while rst rises,
  // so the request in flight must be dropped.
  task automatic reset_pulse(input logic keep_read, input logic [AW-1:0] ra);
    @(negedge clk);
    bus1.read_enable  = keep_read;
    bus1.read_addr    = ra;
    bus1.write_enable = 1'b0;
    #2 rst = 1'b1;
    clear_model();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    bus1.read_enable = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held1, held2;
    int            vcount;
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    clear_model();
    bus1.read_enable       = 1'b0;
    bus1.read_addr         = '0;
    bus1.write_enable      = 1'b0;
    bus1.write_addr        = '0;
    bus1.write_byte_enable = '0;
    bus1.write_data        = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Preload every word so no read returns unknown data.
    for (int a = 0; a < 2**AW; a++) wr(a[AW-1:0], '1, $urandom);

    // Full-word write, read on the next cycle.
    wr(6'd5, 4'hF, 32'hDEADBEEF);
    rd(6'd5);
    idle(2);
    expect_both("full_word", 32'hDEADBEEF);

    // Byte-merge write.
    wr(6'd3, 4'hF, 32'h11223344);
    wr(6'd3, 4'h5, 32'hAABBCCDD);
    rd(6'd3);
    idle(2);
    expect_both("byte_merge", 32'h11BB33DD);

    // Same-address read/write collision.
    wr(6'd7, 4'hF, 32'h0);
    cycle(1'b1, 6'd7, 1'b1, 6'd7, 4'h3, 32'hFFFFFFFF);
    idle(2);
`ifdef MFP_DPRAM_WRITE_BYPASS_EN
    expect_both("collision", 32'h0000FFFF);
`else
    expect_both("collision", 32'h00000000);
`endif
    rd(6'd7);
    idle(2);
    expect_both("after_collision", 32'h0000FFFF);

    // Reset while a request is still being issued, then while the
    // two-cycle instance still has one in flight.
    reset_pulse(1'b1, 6'd3);
    idle(3);
    rd(6'd3);
    reset_pulse(1'b0, 6'd0);
    idle(3);
    rd(6'd5);
    idle(2);
    expect_both("survives_reset", 32'hDEADBEEF);

    // Idle: mask-zero writes must change nothing.
    held1 = bus1.read_data;
    held2 = bus2.read_data;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, (i % 2 == 0) ? 6'd5 : 6'd3, 4'h0, $urandom);
    check("idle_hold_l1", bus1.read_data, held1);
    check("idle_hold_l2", bus2.read_data, held2);
    rd(6'd5);
    rd(6'd3);
    idle(2);
    expect_both("idle_mem", 32'h11BB33DD);

    // Streaming reads of every address on consecutive cycles.
    vcount = 0;
    for (int a = 0; a < 2**AW; a++) begin
      rd(a[AW-1:0]);
      if (bus2.read_valid) vcount++;
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (bus2.read_valid) vcount++;
    end
    check("stream_count", vcount, 64);
    expect_both("stream_last", ref_mem[2**AW-1]);

    // Randomised traffic, biased towards a few addresses for collisions.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ra, wa;
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      cycle($urandom_range(0, 9) < 7, ra, $urandom_range(0, 1) == 1, wa, NB'($urandom), $urandom);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
